// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared states, constants and quarter-wave sine table for rotate_scheduler
package rotate_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_DONE
  } state_e;

  localparam int SCALE_SHIFT = 12;
  localparam int ROUND_BIAS  = 2048;
  localparam int ANGLE_HALF  = 180;
  localparam int LOOKUP_STEP = 4;
  localparam int TRIG_W      = 14;
  localparam int TRIG_MAG_W  = TRIG_W - 1;

  // round(4096 * sin(deg)) for even degrees 0..90; odd inputs never occur
  function automatic logic [TRIG_MAG_W-1:0] sin_even(input logic [6:0] deg);
    logic [TRIG_MAG_W-1:0] m;
    case (deg)
      7'd0:  m = 13'd0;    7'd2:  m = 13'd143;  7'd4:  m = 13'd286;  7'd6:  m = 13'd428;
      7'd8:  m = 13'd570;  7'd10: m = 13'd711;  7'd12: m = 13'd852;  7'd14: m = 13'd991;
      7'd16: m = 13'd1129; 7'd18: m = 13'd1266; 7'd20: m = 13'd1401; 7'd22: m = 13'd1534;
      7'd24: m = 13'd1666; 7'd26: m = 13'd1796; 7'd28: m = 13'd1923; 7'd30: m = 13'd2048;
      7'd32: m = 13'd2171; 7'd34: m = 13'd2290; 7'd36: m = 13'd2408; 7'd38: m = 13'd2522;
      7'd40: m = 13'd2633; 7'd42: m = 13'd2741; 7'd44: m = 13'd2845; 7'd46: m = 13'd2946;
      7'd48: m = 13'd3044; 7'd50: m = 13'd3138; 7'd52: m = 13'd3228; 7'd54: m = 13'd3314;
      7'd56: m = 13'd3396; 7'd58: m = 13'd3474; 7'd60: m = 13'd3547; 7'd62: m = 13'd3617;
      7'd64: m = 13'd3681; 7'd66: m = 13'd3742; 7'd68: m = 13'd3798; 7'd70: m = 13'd3849;
      7'd72: m = 13'd3896; 7'd74: m = 13'd3937; 7'd76: m = 13'd3974; 7'd78: m = 13'd4006;
      7'd80: m = 13'd4034; 7'd82: m = 13'd4056; 7'd84: m = 13'd4074; 7'd86: m = 13'd4086;
      7'd88: m = 13'd4094; 7'd90: m = 13'd4096;
      default: m = 13'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rotate_cos_lut.sv
// rtl/rotate_cos_lut.sv - cosine magnitude/sign for a folded angle in 0..176 degrees
module rotate_cos_lut
  import rotate_pkg::*;
(
  input  logic [7:0]            angle_i,
  output logic [TRIG_MAG_W-1:0] mag_o,
  output logic                  neg_o
);

  logic [6:0] d;

  // cos(a) = sin(90-a) below 90 degrees, -sin(a-90) above
  always_comb begin
    d     = (angle_i <= 8'd90) ? 7'(8'd90 - angle_i) : 7'(angle_i - 8'd90);
    mag_o = sin_even(d);
    neg_o = (angle_i > 8'd90);
  end

endmodule

// File: rtl/rotate_rr_arbiter.sv
// rtl/rotate_rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module rotate_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [2:0]       rr_ptr_i,
  input  logic             enable_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [2:0]       grant_idx_o
);

  int   idx;
  logic found;

  // Scan requesters in circular order from rr_ptr; the first valid one wins
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr_i) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (enable_i && !found && (i == idx) && req_valid_i[i]) begin
          grant_o[i]  = 1'b1;
          grant_idx_o = 3'(i);
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rotate_sin_lut.sv
// rtl/rotate_sin_lut.sv - sine magnitude/sign for a folded angle in 0..176 degrees
module rotate_sin_lut
  import rotate_pkg::*;
(
  input  logic [7:0]            angle_i,
  output logic [TRIG_MAG_W-1:0] mag_o,
  output logic                  neg_o
);

  logic [6:0] d;

  // sin is symmetric about 90 degrees and non-negative over 0..180
  always_comb begin
    d     = (angle_i <= 8'd90) ? 7'(angle_i) : 7'(8'(ANGLE_HALF) - angle_i);
    mag_o = sin_even(d);
    neg_o = 1'b0;
  end

endmodule

// File: rtl/rotate_scheduler.sv
// rtl/rotate_scheduler.sv - shared trig/multiplier point rotator; ROTATE_ROUNDING_EN selects round-half-up
module rotate_scheduler #(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*COORD_W-1:0]   req_x,
  input  logic [N_REQ*COORD_W-1:0]   req_y,
  input  logic [N_REQ*8-1:0]         req_angle,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [COORD_W-1:0]  out_x,
  output logic signed [COORD_W-1:0]  out_y,
  output logic [2:0]                 out_id,
  output logic                       busy
);
  import rotate_pkg::*;

  localparam int ACC_W     = COORD_W + 15;
  localparam int SAT_MAX_I = (1 << (COORD_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_I - 1);

  state_e                     state_q, state_d;
  logic [2:0]                 rr_ptr_q, id_q, out_id_q;
  logic signed [COORD_W-1:0]  x_q, y_q, out_x_q, out_y_q;
  logic [7:0]                 ang_q;
  logic                       neg_q;
  logic signed [TRIG_W-1:0]   sin_q, cos_q, sin_val, cos_val;
  logic signed [ACC_W-1:0]    acc_x_q, acc_y_q;

  logic [N_REQ-1:0]           grant;
  logic [2:0]                 grant_idx;
  logic                       accept;
  logic signed [COORD_W-1:0]  sel_x, sel_y, mul_a;
  logic [7:0]                 sel_ang, fold_a;
  logic                       fold_neg;
  logic [TRIG_MAG_W-1:0]      sin_mag, cos_mag;
  logic                       sin_neg, cos_neg;
  logic signed [TRIG_W-1:0]   mul_b;
  logic signed [ACC_W-1:0]    mul_a_ext, mul_b_ext, prod;

  // Scale down by 4096 (optionally rounding) and clamp to the coordinate range
  function automatic logic signed [COORD_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
`ifdef ROTATE_ROUNDING_EN
    sh = (acc + ACC_W'(ROUND_BIAS)) >>> SCALE_SHIFT;
`else
    sh = acc >>> SCALE_SHIFT;
`endif
    if (sh > SAT_MAX) return COORD_W'(SAT_MAX);
    if (sh < SAT_MIN) return COORD_W'(SAT_MIN);
    return COORD_W'(sh);
  endfunction

  // Grants only in IDLE and never while reset is held
  rotate_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .enable_i    ((state_q == S_IDLE) && !reset),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  rotate_sin_lut u_sin (.angle_i(ang_q), .mag_o(sin_mag), .neg_o(sin_neg));
  rotate_cos_lut u_cos (.angle_i(ang_q), .mag_o(cos_mag), .neg_o(cos_neg));

  assign accept    = |grant;
  assign req_ready = grant;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

  // Route the winner's request fields and fold its angle into 0..176 in 4-degree steps
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_ang = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_x   = req_x[i*COORD_W +: COORD_W];
        sel_y   = req_y[i*COORD_W +: COORD_W];
        sel_ang = req_angle[i*8 +: 8];
      end
    end
    fold_neg = (sel_ang >= 8'(ANGLE_HALF));
    fold_a   = (fold_neg ? sel_ang - 8'(ANGLE_HALF) : sel_ang) & ~8'(LOOKUP_STEP - 1);
  end

  // Apply table sign and the 180-degree half-turn sign, then pick multiplier operands by step
  always_comb begin
    sin_val   = (sin_neg ^ neg_q) ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
    cos_val   = (cos_neg ^ neg_q) ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
    mul_a     = (state_q == S_MUL0 || state_q == S_MUL2) ? x_q : y_q;
    mul_b     = (state_q == S_MUL0 || state_q == S_MUL3) ? cos_q : sin_q;
    mul_a_ext = ACC_W'(mul_a);
    mul_b_ext = ACC_W'(mul_b);
    prod      = mul_a_ext * mul_b_ext;
  end

  // Next-state sequencing: one lookup, four multiply steps, then hold until consumed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_MUL0;
      S_MUL0:   state_d = S_MUL1;
      S_MUL1:   state_d = S_MUL2;
      S_MUL2:   state_d = S_MUL3;
      S_MUL3:   state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request capture, trig registers, accumulators and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ang_q    <= '0;
      neg_q    <= 1'b0;
      sin_q    <= '0;
      cos_q    <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      out_x_q  <= '0;
      out_y_q  <= '0;
      out_id_q <= '0;
    end else begin
      if (accept) begin
        x_q      <= sel_x;
        y_q      <= sel_y;
        ang_q    <= fold_a;
        neg_q    <= fold_neg;
        id_q     <= grant_idx;
        rr_ptr_q <= (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
      end
      case (state_q)
        S_LOOKUP: begin
          sin_q <= sin_val;
          cos_q <= cos_val;
        end
        S_MUL0: acc_x_q <= prod;
        S_MUL1: acc_x_q <= acc_x_q - prod;
        S_MUL2: acc_y_q <= prod;
        S_MUL3: begin
          acc_y_q  <= acc_y_q + prod;
          out_x_q  <= scale_sat(acc_x_q);
          out_y_q  <= scale_sat(acc_y_q + prod);
          out_id_q <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_scheduler.sv
// tb/tb_rotate_scheduler.sv - directed vector bench for rotate_scheduler
module tb_rotate_scheduler;

  localparam int N_REQ   = 4;
  localparam int COORD_W = 11;
`ifdef ROTATE_ROUNDING_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*COORD_W-1:0]  req_x, req_y;
  logic [N_REQ*8-1:0]        req_angle;
  logic                      out_valid, out_ready, busy;
  logic signed [COORD_W-1:0] out_x, out_y;
  logic [2:0]                out_id;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int id; int x; int y; int angle; int ex; int ey;
  } vec_t;
  vec_t vecs[8];

  rotate_scheduler #(.N_REQ(N_REQ), .COORD_W(COORD_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input int id, input int x, input int y, input int a);
    req_x[id*COORD_W +: COORD_W] = COORD_W'(x);
    req_y[id*COORD_W +: COORD_W] = COORD_W'(y);
    req_angle[id*8 +: 8]         = 8'(a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present a request mask, check the grant, let it be accepted; returns in cycle 1
  task automatic issue(input logic [3:0] mask, input logic [3:0] exp_rdy, input string nm);
    @(negedge clk);
    req_valid = mask;
    #1;
    check({nm, "_ready"}, int'(req_ready), int'(exp_rdy));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_req(input int ex, input int ey, input int eid, input string nm);
    int lat;
    wait_valid(lat);
    check({nm, "_lat"}, lat, 6);
    check({nm, "_x"}, int'(out_x), ex);
    check({nm, "_y"}, int'(out_y), ey);
    check({nm, "_id"}, int'(out_id), eid);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int lat, cyc, got, prev;
    logic signed [COORD_W-1:0] hx, hy;

    vecs[0] = '{0, 100, 0, 0, 100, 0};
    vecs[1] = '{1, 100, 0, 88, 3, RND ? 100 : 99};
    vecs[2] = '{2, 100, 100, 60, -37, RND ? 137 : 136};
    vecs[3] = '{3, 100, 0, 180, -100, 0};
    vecs[4] = '{0, 1023, 1023, 44, 25, 1023};
    vecs[5] = '{1, 100, 0, 90, 3, RND ? 100 : 99};
    vecs[6] = '{2, 100, 0, 255, -31, RND ? -95 : -96};
    vecs[7] = '{3, -1024, -1024, 44, RND ? -25 : -26, -1024};

    reset = 1'b1; req_valid = '0; out_ready = 1'b0;
    req_x = '0; req_y = '0; req_angle = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_x", int'(out_x), 0);
    check("rst_y", int'(out_y), 0);
    check("rst_id", int'(out_id), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].angle);
      issue(4'(1 << vecs[i].id), 4'(1 << vecs[i].id), $sformatf("vec%0d", i));
      finish_req(vecs[i].ex, vecs[i].ey, vecs[i].id, $sformatf("vec%0d", i));
    end

    // All four requesting continuously with out_ready high: 0,1,2,3,0 every 7 cycles
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 10 * (i + 1), 0, 0);
    @(negedge clk);
    req_valid = '1; out_ready = 1'b1;
    cyc = 0; got = 0; prev = 0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check($sformatf("rr%0d_id", got), int'(out_id), got % 4);
        check($sformatf("rr%0d_x", got), int'(out_x), 10 * (got % 4 + 1));
        check($sformatf("rr%0d_gap", got), cyc - prev, (got == 0) ? 6 : 7);
        prev = cyc;
        got++;
        if (got == 5) req_valid = '0;
      end
    end
    check("rr_count", got, 5);
    @(negedge clk);
    out_ready = 1'b0;

    // Pointer behaviour: only 2 valid with rr_ptr=3, then wrap to 0, then 2 from ptr=1
    do_reset();
    set_req(0, 50, 0, 0);
    set_req(2, 60, 0, 0);
    issue(4'b0100, 4'b0100, "p2");
    finish_req(60, 0, 2, "p2");
    issue(4'b0100, 4'b0100, "only2_ptr3");
    finish_req(60, 0, 2, "only2_ptr3");
    issue(4'b0101, 4'b0001, "wrap0");
    finish_req(50, 0, 0, "wrap0");
    issue(4'b0101, 4'b0100, "rr2");
    finish_req(60, 0, 2, "rr2");

    // Dropping valid before a grant edge: no accept, pointer unchanged (still 3)
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("drop_ready", int'(req_ready), 2);
    #2;
    req_valid = '0;
    @(posedge clk);
    #1;
    check("drop_busy", int'(busy), 0);
    issue(4'b0101, 4'b0001, "drop_ptr");
    finish_req(50, 0, 0, "drop_ptr");

    // Back-pressure: outputs hold for 10 cycles and other requesters are not granted
    set_req(1, 100, 100, 60);
    issue(4'b0010, 4'b0010, "stall");
    wait_valid(lat);
    check("stall_lat", lat, 6);
    hx = out_x; hy = out_y;
    check("stall_x0", int'(hx), -37);
    req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_v", k), int'(out_valid), 1);
      check($sformatf("stall%0d_x", k), int'(out_x), int'(hx));
      check($sformatf("stall%0d_y", k), int'(out_y), int'(hy));
      check($sformatf("stall%0d_rdy", k), int'(req_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    req_valid = '0;

    // Reset during MUL1 discards the request; re-request is accepted after release
    set_req(3, 100, 0, 88);
    issue(4'b1000, 4'b1000, "rst_req");
    @(negedge clk); @(negedge clk);
    check("mul1_busy", int'(busy), 1);
    reset = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("mr_ready", int'(req_ready), 0);
    check("mr_valid", int'(out_valid), 0);
    check("mr_x", int'(out_x), 0);
    check("mr_y", int'(out_y), 0);
    check("mr_id", int'(out_id), 0);
    check("mr_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check("mr_hold_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_reaccept", int'(req_ready), 8);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    finish_req(3, RND ? 100 : 99, 3, "mr_redo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
